// File: rtl/keccak_byte_packer.sv
// Byte-stream front end for the keccak core: packs framed bytes into 32-bit
// words, pulses the core reset per message and applies the last-word padding rules.
module keccak_byte_packer #(
    parameter int RESET_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    input  logic        s_nodata,
    output logic        s_ready,
    output logic        k_reset,
    output logic [31:0] k_in,
    output logic        k_in_ready,
    output logic        k_is_last,
    output logic [1:0]  k_byte_num,
    input  logic        k_buffer_full,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, RST, ACC, PAD, DRAIN} state_t;

    state_t      state, state_nx;
    logic [3:0]  rst_cnt, rst_cnt_nx;
    logic [23:0] acc, acc_nx;
    logic [1:0]  cnt, cnt_nx;
    logic        pad_pend, pad_pend_nx;
    logic        k_reset_nx;
    logic [31:0] k_in_nx;
    logic        k_in_ready_nx;
    logic        k_is_last_nx;
    logic [1:0]  k_byte_num_nx;

    logic       xfer;
    logic       out_free;
    logic       accept;
    logic [2:0] n_last;

    // The newest byte sits in the low lane; move the n valid bytes to the top.
    function automatic logic [31:0] left_just(input logic [31:0] v, input logic [2:0] n);
        logic [31:0] r;
        case (n)
            3'd1:    r = {v[7:0], 24'h0};
            3'd2:    r = {v[15:0], 16'h0};
            3'd3:    r = {v[23:0], 8'h0};
            3'd4:    r = v;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    assign xfer     = k_in_ready && !k_buffer_full;
    assign out_free = !k_in_ready || !k_buffer_full;
    assign s_ready  = (state == ACC) && out_free;
    assign busy     = (state != IDLE);
    assign accept   = s_valid && s_ready;
    assign n_last   = {1'b0, cnt} + 3'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rst_cnt    <= 4'd0;
            acc        <= 24'h0;
            cnt        <= 2'd0;
            pad_pend   <= 1'b0;
            k_reset    <= 1'b0;
            k_in       <= 32'h0;
            k_in_ready <= 1'b0;
            k_is_last  <= 1'b0;
            k_byte_num <= 2'd0;
        end else begin
            state      <= state_nx;
            rst_cnt    <= rst_cnt_nx;
            acc        <= acc_nx;
            cnt        <= cnt_nx;
            pad_pend   <= pad_pend_nx;
            k_reset    <= k_reset_nx;
            k_in       <= k_in_nx;
            k_in_ready <= k_in_ready_nx;
            k_is_last  <= k_is_last_nx;
            k_byte_num <= k_byte_num_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        rst_cnt_nx    = rst_cnt;
        acc_nx        = acc;
        cnt_nx        = cnt;
        pad_pend_nx   = pad_pend;
        k_reset_nx    = k_reset;
        k_in_nx       = k_in;
        k_in_ready_nx = k_in_ready;
        k_is_last_nx  = k_is_last;
        k_byte_num_nx = k_byte_num;

        // A word leaving with nothing new behind it empties the output register.
        if (xfer) k_in_ready_nx = 1'b0;

        case (state)
            IDLE: begin
                if (s_valid) begin
                    state_nx   = RST;
                    k_reset_nx = 1'b1;
                    rst_cnt_nx = 4'(RESET_CYCLES);
                    acc_nx     = 24'h0;
                    cnt_nx     = 2'd0;
                end
            end
            RST: begin
                if (rst_cnt <= 4'd1) begin
                    k_reset_nx = 1'b0;
                    state_nx   = ACC;
                end else begin
                    rst_cnt_nx = rst_cnt - 4'd1;
                end
            end
            ACC: begin
                if (accept) begin
                    if (s_last && s_nodata) begin
                        k_in_nx       = left_just({8'h0, acc}, {1'b0, cnt});
                        k_in_ready_nx = 1'b1;
                        k_is_last_nx  = 1'b1;
                        k_byte_num_nx = cnt;
                        cnt_nx        = 2'd0;
                        state_nx      = DRAIN;
                    end else if (s_last) begin
                        k_in_nx       = left_just({acc, s_data}, n_last);
                        k_in_ready_nx = 1'b1;
                        cnt_nx        = 2'd0;
                        if (cnt == 2'd3) begin
                            // Aligned length: the core still needs an empty last word.
                            k_is_last_nx  = 1'b0;
                            k_byte_num_nx = 2'd0;
                            pad_pend_nx   = 1'b1;
                            state_nx      = PAD;
                        end else begin
                            k_is_last_nx  = 1'b1;
                            k_byte_num_nx = n_last[1:0];
                            state_nx      = DRAIN;
                        end
                    end else if (cnt == 2'd3) begin
                        k_in_nx       = {acc, s_data};
                        k_in_ready_nx = 1'b1;
                        k_is_last_nx  = 1'b0;
                        k_byte_num_nx = 2'd0;
                        cnt_nx        = 2'd0;
                    end else begin
                        acc_nx = {acc[15:0], s_data};
                        cnt_nx = cnt + 2'd1;
                    end
                end
            end
            PAD: begin
                if (out_free && pad_pend) begin
                    k_in_nx       = 32'h0;
                    k_in_ready_nx = 1'b1;
                    k_is_last_nx  = 1'b1;
                    k_byte_num_nx = 2'd0;
                    pad_pend_nx   = 1'b0;
                    state_nx      = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    k_in_ready_nx = 1'b0;
                    k_is_last_nx  = 1'b0;
                    k_byte_num_nx = 2'd0;
                    state_nx      = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Directed bench for keccak_byte_packer: one instance with a 1-cycle core reset
// pulse and one with a 3-cycle pulse; word transfers are logged at the falling edge.
module tb_keccak_byte_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data[2];
    logic        s_valid[2];
    logic        s_last[2];
    logic        s_nodata[2];
    logic        s_ready[2];
    logic        k_reset[2];
    logic [31:0] k_in[2];
    logic        k_in_ready[2];
    logic        k_is_last[2];
    logic [1:0]  k_byte_num[2];
    logic        bf[2];
    logic        busy[2];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keccak_byte_packer #(.RESET_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .s_data(s_data[0]), .s_valid(s_valid[0]),
        .s_last(s_last[0]), .s_nodata(s_nodata[0]), .s_ready(s_ready[0]),
        .k_reset(k_reset[0]), .k_in(k_in[0]), .k_in_ready(k_in_ready[0]),
        .k_is_last(k_is_last[0]), .k_byte_num(k_byte_num[0]),
        .k_buffer_full(bf[0]), .busy(busy[0])
    );

    keccak_byte_packer #(.RESET_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .s_data(s_data[1]), .s_valid(s_valid[1]),
        .s_last(s_last[1]), .s_nodata(s_nodata[1]), .s_ready(s_ready[1]),
        .k_reset(k_reset[1]), .k_in(k_in[1]), .k_in_ready(k_in_ready[1]),
        .k_is_last(k_is_last[1]), .k_byte_num(k_byte_num[1]),
        .k_buffer_full(bf[1]), .busy(busy[1])
    );

    // Transfer log: a word pending with buffer_full low at the falling edge moves on the next rising edge.
    logic [31:0] xw[2][64];
    logic        xl[2][64];
    logic [1:0]  xb[2][64];
    int          xc[2][64];
    int          xn[2];
    int          pulses[2];
    int          rst_hi[2];
    bit          krp[2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            xn[d] = 0; pulses[d] = 0; rst_hi[d] = 0; krp[d] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (k_in_ready[d] && !bf[d] && xn[d] < 64) begin
                xw[d][xn[d]] <= k_in[d];
                xl[d][xn[d]] <= k_is_last[d];
                xb[d][xn[d]] <= k_byte_num[d];
                xc[d][xn[d]] <= cyc;
                xn[d]        <= xn[d] + 1;
            end
            if (k_reset[d] && !krp[d]) pulses[d] <= pulses[d] + 1;
            if (k_reset[d]) rst_hi[d] <= rst_hi[d] + 1;
            krp[d] <= k_reset[d];
        end
    end

    typedef struct {
        string            msg;
        bit               nd;
        int               nw;
        logic [0:5][31:0] w;
        logic [1:0]       bn;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_beat(input int d, input logic [7:0] b, input logic last, input logic nd);
        bit got;
        got = 1'b0;
        s_valid[d] = 1'b1; s_data[d] = b; s_last[d] = last; s_nodata[d] = nd;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s_ready[d]) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        s_valid[d] = 1'b0; s_last[d] = 1'b0; s_nodata[d] = 1'b0;
        chk("beat accepted", 32'(got), 32'd1);
    endtask

    task automatic send_msg(input int d, input string m, input bit nd);
        for (int i = 0; i < m.len(); i++)
            send_beat(d, m[i], (i == m.len() - 1) && !nd, 1'b0);
        if (nd) send_beat(d, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic wait_idle(input int d, output int idle_cyc);
        bit got;
        got = 1'b0;
        idle_cyc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy[d]) begin
                got = 1'b1;
                idle_cyc = cyc;
                break;
            end
        end
        chk("reached idle", 32'(got), 32'd1);
    endtask

    task automatic check_xfers(input int d, input int base, input int nw,
                               input logic [0:5][31:0] w, input logic [1:0] bn, input string nm);
        for (int i = 0; i < nw; i++) begin
            chk($sformatf("%s word%0d data", nm, i), xw[d][base + i], w[i]);
            chk($sformatf("%s word%0d is_last", nm, i), 32'(xl[d][base + i]), 32'(i == nw - 1));
            chk($sformatf("%s word%0d byte_num", nm, i), 32'(xb[d][base + i]),
                (i == nw - 1) ? 32'(bn) : 32'd0);
        end
    endtask

    task automatic check_outputs_zero(input int d, input string nm);
        chk({nm, " s_ready"}, 32'(s_ready[d]), 32'd0);
        chk({nm, " k_reset"}, 32'(k_reset[d]), 32'd0);
        chk({nm, " k_in"}, k_in[d], 32'd0);
        chk({nm, " k_in_ready"}, 32'(k_in_ready[d]), 32'd0);
        chk({nm, " k_is_last"}, 32'(k_is_last[d]), 32'd0);
        chk({nm, " k_byte_num"}, 32'(k_byte_num[d]), 32'd0);
        chk({nm, " busy"}, 32'(busy[d]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, pb, hb, idle_c;
        bit found;

        vt[0] = '{"Hello, world!", 1'b0, 4,
                  {32'h48656C6C, 32'h6F2C2077, 32'h6F726C64, 32'h21000000, 64'h0}, 2'd1};
        vt[1] = '{"abcd", 1'b0, 2, {32'h61626364, 32'h00000000, 128'h0}, 2'd0};
        vt[2] = '{"", 1'b1, 1, {32'h00000000, 160'h0}, 2'd0};
        vt[3] = '{"abcde", 1'b1, 2, {32'h61626364, 32'h65000000, 128'h0}, 2'd1};
        vt[4] = '{"xyz", 1'b1, 1, {32'h78797A00, 160'h0}, 2'd3};
        vt[5] = '{"wxyz", 1'b1, 2, {32'h7778797A, 32'h00000000, 128'h0}, 2'd0};

        for (int d = 0; d < 2; d++) begin
            s_data[d] = 8'h0; s_valid[d] = 1'b0; s_last[d] = 1'b0; s_nodata[d] = 1'b0; bf[d] = 1'b0;
        end
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check_outputs_zero(0, "reset d1");
        check_outputs_zero(1, "reset d3");
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;

        // Table of single messages on the 1-cycle-pulse instance.
        for (int v = 0; v < 6; v++) begin
            base = xn[0]; pb = pulses[0]; hb = rst_hi[0];
            send_msg(0, vt[v].msg, vt[v].nd);
            wait_idle(0, idle_c);
            chk($sformatf("'%s' count", vt[v].msg), 32'(xn[0] - base), 32'(vt[v].nw));
            check_xfers(0, base, vt[v].nw, vt[v].w, vt[v].bn, $sformatf("'%s'", vt[v].msg));
            chk($sformatf("'%s' k_reset pulses", vt[v].msg), 32'(pulses[0] - pb), 32'd1);
            chk($sformatf("'%s' k_reset width", vt[v].msg), 32'(rst_hi[0] - hb), 32'd1);
            chk($sformatf("'%s' idle after last", vt[v].msg), 32'(idle_c),
                32'(xc[0][base + vt[v].nw - 1] + 1));
            repeat (2) @(posedge clk); #1;
        end

        // Backpressure: stall 7 cycles while "quic" is pending.
        base = xn[0];
        found = 1'b0;
        fork
            send_msg(0, "The quick brown fox.", 1'b0);
            begin
                for (int k = 0; k < 100; k++) begin
                    @(posedge clk); #1;
                    if (k_in_ready[0] && k_in[0] == 32'h71756963) begin
                        found = 1'b1;
                        break;
                    end
                end
                if (found) begin
                    bf[0] = 1'b1;
                    repeat (7) begin
                        @(negedge clk);
                        chk("stall k_in", k_in[0], 32'h71756963);
                        chk("stall k_in_ready", 32'(k_in_ready[0]), 32'd1);
                        chk("stall s_ready", 32'(s_ready[0]), 32'd0);
                    end
                    @(posedge clk); #1;
                    bf[0] = 1'b0;
                end
            end
        join
        chk("stall word seen", 32'(found), 32'd1);
        wait_idle(0, idle_c);
        chk("fox count", 32'(xn[0] - base), 32'd6);
        check_xfers(0, base, 6, {32'h54686520, 32'h71756963, 32'h6B206272,
                                 32'h6F776E20, 32'h666F782E, 32'h00000000}, 2'd0, "fox");

        // Back-to-back messages with a 3-cycle core reset.
        base = xn[1]; pb = pulses[1]; hb = rst_hi[1];
        send_msg(1, "1234567890", 1'b0);
        send_msg(1, "xy", 1'b0);
        wait_idle(1, idle_c);
        chk("b2b count", 32'(xn[1] - base), 32'd4);
        check_xfers(1, base, 3, {32'h31323334, 32'h35363738, 32'h39300000, 96'h0}, 2'd2, "msg1");
        check_xfers(1, base + 3, 1, {32'h78790000, 160'h0}, 2'd2, "msg2");
        chk("b2b k_reset pulses", 32'(pulses[1] - pb), 32'd2);
        chk("b2b k_reset width", 32'(rst_hi[1] - hb), 32'd6);

        // Asynchronous abort mid-message, then a clean message.
        send_msg(0, "abcdef", 1'b1 == 1'b0);
        s_valid[0] = 1'b0;
        chk("pre-abort busy", 32'(busy[0]), 32'd1);
        #1 reset = 1'b0;
        #1;
        check_outputs_zero(0, "abort");
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        base = xn[0]; pb = pulses[0];
        send_msg(0, "abc", 1'b0);
        wait_idle(0, idle_c);
        chk("post-abort count", 32'(xn[0] - base), 32'd1);
        check_xfers(0, base, 1, {32'h61626300, 160'h0}, 2'd3, "post-abort");
        chk("post-abort k_reset pulses", 32'(pulses[0] - pb), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
